// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one memory port between an instruction-fetch
// requester and a data requester. Data has priority, but fetch wins once it
// has waited through STARVE_LIMIT consecutive data grants. Each access is
// bounded by TIMEOUT busy cycles; an expired access completes with zero data
// and a one-cycle bus_err pulse.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // data requester
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_type,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_type,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
  localparam logic [2:0]    TYPE_WORD  = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t        state_q;
  logic [31:0]   addr_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [2:0]    type_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   dm_rdata_q;
  logic          if_rvalid_q;
  logic          dm_rvalid_q;
  logic          bus_err_q;
  logic [SW-1:0] starve_cnt_q;
  logic [WW-1:0] wait_cnt_q;

  logic          sel_dm_d;
  logic          sel_if_d;
  logic          if_gnt_d;
  logic          dm_gnt_d;

  // Arbitration: data first, unless fetch has been starved to the limit.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    sel_dm_d = 1'b0;
    sel_if_d = 1'b0;
    if_gnt_d = 1'b0;
    dm_gnt_d = 1'b0;
    sel_dm_d = dm_req && !(if_req && (starve_cnt_q == STARVE_MAX));
    sel_if_d = if_req && !sel_dm_d;
    if (rst_n && (state_q == IDLE)) begin
      dm_gnt_d = sel_dm_d;
      if_gnt_d = sel_if_d;
    end
  end

  // Main FSM: grant capture, access tracking, completion and timeout.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      type_q       <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      bus_err_q    <= 1'b0;
      starve_cnt_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dm_gnt_d) begin
            state_q    <= BUSY_DM;
            addr_q     <= dm_addr;
            we_q       <= dm_we;
            wdata_q    <= dm_wdata;
            type_q     <= dm_type;
            wait_cnt_q <= '0;
            if (if_req && (starve_cnt_q != STARVE_MAX)) begin
              starve_cnt_q <= starve_cnt_q + 1'b1;
            end
          end else if (if_gnt_d) begin
            state_q      <= BUSY_IF;
            addr_q       <= if_addr;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            type_q       <= TYPE_WORD;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (mem_ack) begin
            // An ack on the final wait cycle still counts as a normal completion.
            state_q <= IDLE;
            if (state_q == BUSY_IF) begin
              if_rdata_q  <= mem_rdata;
              if_rvalid_q <= 1'b1;
            end else begin
              dm_rdata_q  <= mem_rdata;
              dm_rvalid_q <= 1'b1;
            end
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q   <= IDLE;
            bus_err_q <= 1'b1;
            if (state_q == BUSY_IF) begin
              if_rdata_q  <= '0;
              if_rvalid_q <= 1'b1;
            end else begin
              dm_rdata_q  <= '0;
              dm_rvalid_q <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt    = if_gnt_d;
  assign dm_gnt    = dm_gnt_d;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_type  = type_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 3;
  localparam int TIMEOUT      = 15;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [2:0]  dm_type;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_type;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int checks;
  int failures;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_type(dm_type), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_type(mem_type), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: one access in flight or none.
  bit          m_busy;
  bit          m_dm;       // owner of the access in flight
  int          m_waited;   // busy cycles elapsed without ack
  int          m_run;      // data grants since fetch last won, while fetch waited
  logic [31:0] m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  logic [2:0]  m_type;
  logic [31:0] m_if_rdata;
  logic [31:0] m_dm_rdata;
  logic        m_if_rv;
  logic        m_dm_rv;
  logic        m_err;
  logic        g_if;
  logic        g_dm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_dm = 0; m_waited = 0; m_run = 0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0; m_type = '0;
    m_if_rdata = '0; m_dm_rdata = '0;
    m_if_rv = 1'b0; m_dm_rv = 1'b0; m_err = 1'b0;
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic eval();
    #1;
    if (!rst_n) model_reset();
    g_dm = rst_n && !m_busy && dm_req && !(if_req && (m_run == STARVE_LIMIT));
    g_if = rst_n && !m_busy && if_req && !g_dm;
    check("if_gnt",    if_gnt,    g_if);
    check("dm_gnt",    dm_gnt,    g_dm);
    check("mem_req",   mem_req,   m_busy);
    check("mem_addr",  mem_addr,  m_addr);
    check("mem_we",    mem_we,    m_we);
    check("mem_wdata", mem_wdata, m_wdata);
    check("mem_type",  mem_type,  m_type);
    check("if_rvalid", if_rvalid, m_if_rv);
    check("dm_rvalid", dm_rvalid, m_dm_rv);
    check("if_rdata",  if_rdata,  m_if_rdata);
    check("dm_rdata",  dm_rdata,  m_dm_rdata);
    check("bus_err",   bus_err,   m_err);
  endtask

  // Apply this cycle's clock edge to the model, then move to the next cycle.
  task automatic adv();
    logic nif_rv, ndm_rv, nerr;
    nif_rv = 1'b0; ndm_rv = 1'b0; nerr = 1'b0;
    if (rst_n) begin
      if (m_busy) begin
        if (mem_ack || (m_waited == TIMEOUT - 1)) begin
          if (m_dm) begin
            ndm_rv = 1'b1;
            m_dm_rdata = mem_ack ? mem_rdata : 32'h0;
          end else begin
            nif_rv = 1'b1;
            m_if_rdata = mem_ack ? mem_rdata : 32'h0;
          end
          nerr = !mem_ack;
          m_busy = 0;
        end else begin
          m_waited++;
        end
      end else if (g_dm) begin
        m_busy = 1; m_dm = 1; m_waited = 0;
        m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; m_type = dm_type;
        if (if_req && (m_run < STARVE_LIMIT)) m_run++;
      end else if (g_if) begin
        m_busy = 1; m_dm = 0; m_waited = 0;
        m_addr = if_addr; m_we = 1'b0; m_wdata = 32'h0; m_type = 3'b010;
        m_run = 0;
      end
      m_if_rv = nif_rv; m_dm_rv = ndm_rv; m_err = nerr;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    string seq;
    int    gcount;
    int    rv_cnt;
    int    busy_cnt;
    bit    done;

    checks = 0; failures = 0;
    model_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_type = '0; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);

    // Reset: requests are held high to show grants stay low under reset.
    if_req = 1'b1; dm_req = 1'b1; mem_ack = 1'b1;
    repeat (2) begin eval(); adv(); end
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;

    // Fetch only, granted on the first edge after reset release.
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h100;
    eval(); check("fo_gnt", if_gnt, 1'b1); adv();
    if_req = 1'b0; if_addr = 32'hFFFF_0000; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    eval(); check("fo_mreq", mem_req, 1'b1); check("fo_maddr", mem_addr, 32'h100);
    check("fo_mtype", mem_type, 3'b010); adv();
    mem_ack = 1'b0; mem_rdata = 32'h1234_5678;
    eval(); check("fo_rvalid", if_rvalid, 1'b1); check("fo_rdata", if_rdata, 32'hDEAD_BEEF); adv();

    // Store held until a late ack; request inputs change mid-access.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h55; dm_type = 3'b000;
    eval(); check("st_gnt", dm_gnt, 1'b1); adv();
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'hBAD0; dm_wdata = 32'hAA; dm_type = 3'b111;
    rv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ack = (i == 2); mem_rdata = 32'h0000_00C3;
      eval();
      if (i < 3) begin
        check("st_mwe", mem_we, 1'b1);
        check("st_maddr", mem_addr, 32'h2000);
        check("st_mwdata", mem_wdata, 32'h55);
        check("st_mtype", mem_type, 3'b000);
      end
      if (dm_rvalid) rv_cnt++;
      adv();
    end
    check("st_rv_once", rv_cnt, 1);
    mem_ack = 1'b0;

    // Starvation with both requesting and ack every access.
    dm_req = 1'b1; if_req = 1'b1; mem_ack = 1'b1; seq = ""; gcount = 0;
    for (int i = 0; i < 24 && gcount < 8; i++) begin
      eval();
      if (dm_gnt) begin seq = {seq, "D"}; gcount++; end
      else if (if_gnt) begin seq = {seq, "F"}; gcount++; end
      adv();
    end
    checks++;
    assert (seq == "DDDFDDDF") else begin
      failures++;
      $error("FAIL starve_seq observed=%s expected=DDDFDDDF", seq);
    end
    dm_req = 1'b0; if_req = 1'b0;
    repeat (2) begin eval(); adv(); end
    mem_ack = 1'b0;

    // Timeout on a data load.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = $urandom; dm_type = 3'b010;
    eval(); adv();
    dm_req = 1'b0; busy_cnt = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      eval();
      if (mem_req) busy_cnt++;
      if (dm_rvalid) begin
        done = 1;
        check("to_err", bus_err, 1'b1);
        check("to_rdata", dm_rdata, 32'h0);
        check("to_idle", mem_req, 1'b0);
      end
      adv();
    end
    check("to_done", done, 1'b1);
    check("to_busy_cycles", busy_cnt, TIMEOUT);

    // Ack arriving on the last allowed busy cycle.
    dm_req = 1'b1; dm_addr = 32'h3000;
    eval(); adv();
    dm_req = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      mem_ack = (i == TIMEOUT); mem_rdata = 32'hCAFE_0001;
      eval(); adv();
    end
    mem_ack = 1'b0;
    eval(); check("at_rv", dm_rvalid, 1'b1); check("at_err", bus_err, 1'b0);
    check("at_rdata", dm_rdata, 32'hCAFE_0001); adv();

    // Reset in the middle of a data access.
    dm_req = 1'b1; dm_addr = 32'h4000;
    eval(); adv();
    dm_req = 1'b0;
    eval(); check("mr_busy", mem_req, 1'b1); adv();
    rst_n = 1'b0;
    eval(); check("mr_mreq", mem_req, 1'b0); adv();
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h500;
    eval(); check("mr_ifgnt", if_gnt, 1'b1); adv();
    if_req = 1'b0; mem_ack = 1'b1; rv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      eval(); if (dm_rvalid) rv_cnt++; adv();
    end
    check("mr_no_dmrv", rv_cnt, 0);

    // Random traffic: alternating fast-ack and mostly-silent memory phases.
    for (int c = 0; c < 1500; c++) begin
      if_req    = ($urandom_range(0, 3) != 0);
      dm_req    = ($urandom_range(0, 2) != 0);
      if_addr   = $urandom;
      dm_addr   = $urandom;
      dm_we     = $urandom_range(0, 1);
      dm_wdata  = $urandom;
      dm_type   = 3'($urandom_range(0, 7));
      mem_ack   = ($urandom_range(0, 99) < (((c / 300) % 2) == 1 ? 4 : 50));
      mem_rdata = $urandom;
      eval(); adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
